// File: rtl/tagged_normalize.sv
`default_nettype none
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef Q_BITS
`define Q_BITS 16
`endif
// +--------------------------------------------------------------------------+
// | tagged_normalize: scales a tagged Q-format direction to unit length via  |
// | a bit-serial square root and one shared bit-serial divider.  Rev 1.0     |
// +--------------------------------------------------------------------------+
module tagged_normalize #(
  parameter int WIDTH    = `WIDTH,
  parameter int Q_BITS   = `Q_BITS,
  parameter int TAG_SIZE = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  // {tag, x, y, z, pow.x, pow.y, pow.z}, MSB first
  input  logic [TAG_SIZE+6*WIDTH-1:0]   tdp_in,
  output logic                          ready,
  output logic                          valid,
  output logic                          zero_len,
  // {tag, x, y, z}, MSB first
  output logic [TAG_SIZE+3*WIDTH-1:0]   dir_out
);
  localparam int RADW = WIDTH + 2 + Q_BITS;
  localparam int R    = (RADW + 1) / 2;
  localparam int PADW = 2 * R;
  localparam int RW   = R + 4;
  localparam int DW   = WIDTH + Q_BITS;
  localparam int REMW = DW + 1;
  localparam int CW   = $clog2((WIDTH > R) ? WIDTH : R) + 1;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1) << Q_BITS;
  localparam logic [CW-1:0]    SQRT_LAST = CW'(R - 1);
  localparam logic [CW-1:0]    DIV_LAST  = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SQRT  = 3'd1;
  localparam logic [2:0] S_DIV_X = 3'd2;
  localparam logic [2:0] S_DIV_Y = 3'd3;
  localparam logic [2:0] S_DIV_Z = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [TAG_SIZE-1:0]         tag_q, tag_d;
  logic [WIDTH-1:0]            x_q, x_d, y_q, y_d, z_q, z_d;
  logic [PADW-1:0]             rad_q, rad_d;
  logic [RW-1:0]               srem_q, srem_d;
  logic [R-1:0]                root_q, root_d, m_q, m_d;
  logic [REMW-1:0]             rem_q, rem_d;
  logic [WIDTH-1:0]            dvd_q, dvd_d, quo_q, quo_d;
  logic                        ovf_q, ovf_d, neg_q, neg_d;
  logic [WIDTH-1:0]            sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
  logic [TAG_SIZE+3*WIDTH-1:0] dir_q, dir_d;
  logic                        valid_q, valid_d, zl_q, zl_d;

  logic [TAG_SIZE-1:0] w_in_tag;
  logic [WIDTH-1:0]    w_in_x, w_in_y, w_in_z, w_pow_x, w_pow_y, w_pow_z;
  logic [WIDTH+1:0]    w_sum;
  assign {w_in_tag, w_in_x, w_in_y, w_in_z, w_pow_x, w_pow_y, w_pow_z} = tdp_in;
  assign w_sum = {2'b00, w_pow_x} + {2'b00, w_pow_y} + {2'b00, w_pow_z};

  logic w_sqrt_last, w_div_last;
  assign w_sqrt_last = (cnt_q == SQRT_LAST);
  assign w_div_last  = (cnt_q == DIV_LAST);

  // Non-restoring root step: the remainder sign picks add or subtract next cycle.
  logic [RW-1:0] w_srem_sh, w_srem_next, w_add, w_sub;
  logic [R-1:0]  w_root_next;
  assign w_srem_sh   = (srem_q << 2) | {{(RW-2){1'b0}}, rad_q[PADW-1 -: 2]};
  assign w_add       = {{(RW-R-2){1'b0}}, root_q, 2'b11};
  assign w_sub       = {{(RW-R-2){1'b0}}, root_q, 2'b01};
  assign w_srem_next = srem_q[RW-1] ? (w_srem_sh + w_add) : (w_srem_sh - w_sub);
  assign w_root_next = (root_q << 1) | {{(R-1){1'b0}}, ~w_srem_next[RW-1]};

  // Operand for the divider pass that starts on the current phase's last edge.
  logic [WIDTH-1:0] w_ld_c, w_ld_abs;
  logic [DW-1:0]    w_ld_dvd;
  assign w_ld_c   = (state_q == S_SQRT) ? x_q : ((state_q == S_DIV_X) ? y_q : z_q);
  assign w_ld_abs = w_ld_c[WIDTH-1] ? (-w_ld_c) : w_ld_c;
  assign w_ld_dvd = {w_ld_abs, {Q_BITS{1'b0}}};

  // Top Q_BITS of the dividend seed the remainder; if they already reach M the
  // quotient cannot fit WIDTH bits and is certainly above ONE.
  logic [REMW-1:0]  w_m_ext, w_rem_sh, w_rem_next;
  logic             w_ge, w_ovf_next;
  logic [WIDTH-1:0] w_quo_next, w_mag, w_res;
  assign w_m_ext    = {{(REMW-R){1'b0}}, m_q};
  assign w_rem_sh   = (rem_q << 1) | {{(REMW-1){1'b0}}, dvd_q[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= w_m_ext);
  assign w_rem_next = w_ge ? (w_rem_sh - w_m_ext) : w_rem_sh;
  assign w_quo_next = (quo_q << 1) | {{(WIDTH-1){1'b0}}, w_ge};
  assign w_ovf_next = ovf_q | (rem_q >= w_m_ext);
  assign w_mag      = (w_ovf_next || (w_quo_next > ONE)) ? ONE : w_quo_next;
  assign w_res      = neg_q ? (-w_mag) : w_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SQRT;
      S_SQRT:  if (w_sqrt_last) state_d = (w_root_next == '0) ? S_DONE : S_DIV_X;
      S_DIV_X: if (w_div_last) state_d = S_DIV_Y;
      S_DIV_Y: if (w_div_last) state_d = S_DIV_Z;
      S_DIV_Z: if (w_div_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready    = (state_q == S_IDLE);
  assign valid    = valid_q;
  assign zero_len = zl_q;
  assign dir_out  = dir_q;

  always_comb begin
    cnt_d = cnt_q;  tag_d = tag_q;  x_d = x_q;  y_d = y_q;  z_d = z_q;
    rad_d = rad_q;  srem_d = srem_q;  root_d = root_q;  m_d = m_q;
    rem_d = rem_q;  dvd_d = dvd_q;  quo_d = quo_q;  ovf_d = ovf_q;  neg_d = neg_q;
    sx_d = sx_q;  sy_d = sy_q;  sz_d = sz_q;  dir_d = dir_q;  zl_d = zl_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        tag_d  = w_in_tag;  x_d = w_in_x;  y_d = w_in_y;  z_d = w_in_z;
        rad_d  = PADW'({w_sum, {Q_BITS{1'b0}}});
        srem_d = '0;  root_d = '0;  cnt_d = '0;
        sx_d   = '0;  sy_d = '0;  sz_d = '0;
      end
      S_SQRT: begin
        rad_d  = rad_q << 2;
        srem_d = w_srem_next;
        root_d = w_root_next;
        cnt_d  = cnt_q + 1'b1;
        if (w_sqrt_last) begin
          m_d   = w_root_next;
          cnt_d = '0;
          rem_d = {{(REMW-Q_BITS){1'b0}}, w_ld_dvd[DW-1 -: Q_BITS]};
          dvd_d = w_ld_dvd[WIDTH-1:0];
          quo_d = '0;  ovf_d = 1'b0;  neg_d = w_ld_c[WIDTH-1];
        end
      end
      S_DIV_X, S_DIV_Y, S_DIV_Z: begin
        rem_d = w_rem_next;
        dvd_d = dvd_q << 1;
        quo_d = w_quo_next;
        ovf_d = w_ovf_next;
        cnt_d = cnt_q + 1'b1;
        if (w_div_last) begin
          if (state_q == S_DIV_X)      sx_d = w_res;
          else if (state_q == S_DIV_Y) sy_d = w_res;
          else                         sz_d = w_res;
          cnt_d = '0;
          rem_d = {{(REMW-Q_BITS){1'b0}}, w_ld_dvd[DW-1 -: Q_BITS]};
          dvd_d = w_ld_dvd[WIDTH-1:0];
          quo_d = '0;  ovf_d = 1'b0;  neg_d = w_ld_c[WIDTH-1];
        end
      end
      S_DONE: begin
        dir_d   = {tag_q, sx_q, sy_q, sz_q};
        zl_d    = (m_q == '0);
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;  tag_q <= '0;  x_q <= '0;  y_q <= '0;  z_q <= '0;
      rad_q <= '0;  srem_q <= '0;  root_q <= '0;  m_q <= '0;
      rem_q <= '0;  dvd_q <= '0;  quo_q <= '0;  ovf_q <= 1'b0;  neg_q <= 1'b0;
      sx_q <= '0;  sy_q <= '0;  sz_q <= '0;
      dir_q <= '0;  valid_q <= 1'b0;  zl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;  tag_q <= tag_d;  x_q <= x_d;  y_q <= y_d;  z_q <= z_d;
      rad_q <= rad_d;  srem_q <= srem_d;  root_q <= root_d;  m_q <= m_d;
      rem_q <= rem_d;  dvd_q <= dvd_d;  quo_q <= quo_d;  ovf_q <= ovf_d;  neg_q <= neg_d;
      sx_q <= sx_d;  sy_q <= sy_d;  sz_q <= sz_d;
      dir_q <= dir_d;  valid_q <= valid_d;  zl_q <= zl_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_tagged_normalize.sv
`default_nettype none
// Bench for tagged_normalize (WIDTH=32, Q_BITS=16): scoreboard of expected
// results built from an independent integer model, compared as valid pulses.
module tb_tagged_normalize;
  localparam int W     = 32;
  localparam int Q     = 16;
  localparam int T     = 64;
  localparam int R     = (W + 2 + Q + 1) / 2;
  localparam int LAT   = R + 3 * W + 1;
  localparam int ZLAT  = R + 1;
  localparam int LIMIT = 400;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [T+6*W-1:0] tdp_in = '0;
  logic             ready, valid, zero_len;
  logic [T+3*W-1:0] dir_out;

  tagged_normalize #(.WIDTH(W), .Q_BITS(Q), .TAG_SIZE(T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tdp_in(tdp_in),
    .ready(ready), .valid(valid), .zero_len(zero_len), .dir_out(dir_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [T+3*W-1:0] dir;
    logic             zl;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Truncated Q-format square as produced by the upstream stage, saturated.
  function automatic logic [31:0] sq(input logic [31:0] c);
    longint s, p;
    s = longint'($signed(c));
    p = (s * s) >>> Q;
    if (p > 64'sd4294967295) p = 64'sd4294967295;
    return p[31:0];
  endfunction

  function automatic longint isqrt(input longint v);
    longint lo, hi, mid;
    lo = 0;
    hi = 64'sd1 <<< 26;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  function automatic logic [31:0] norm_comp(input logic [31:0] c, input longint m);
    longint sc, a, q;
    sc = longint'($signed(c));
    a  = (sc < 0) ? -sc : sc;
    q  = (a <<< Q) / m;
    if (q > (64'sd1 <<< Q)) q = 64'sd1 <<< Q;
    q = (sc < 0) ? -q : q;
    return q[31:0];
  endfunction

  function automatic void push_expect(input logic [63:0] tag, input logic [31:0] x, y, z,
                                      input logic [31:0] px, py, pz);
    exp_t   e;
    longint s, m;
    s = longint'(px) + longint'(py) + longint'(pz);
    m = isqrt(s <<< Q);
    if (m == 0) begin
      e.dir = {tag, 96'b0};
      e.zl  = 1'b1;
      e.lat = ZLAT;
    end else begin
      e.dir = {tag, norm_comp(x, m), norm_comp(y, m), norm_comp(z, m)};
      e.zl  = 1'b0;
      e.lat = LAT;
    end
    sb.push_back(e);
  endfunction

  task automatic scramble();
    for (int i = 0; i < 8; i++) tdp_in[i*32 +: 32] = $urandom();
  endtask

  task automatic rand_vec(output logic [63:0] tag, output logic [31:0] x, y, z);
    tag = {$urandom(), $urandom()};
    x   = 32'($urandom_range(0, 32'h80000)) - 32'h40000;
    y   = 32'($urandom_range(0, 32'h80000)) - 32'h40000;
    z   = 32'($urandom_range(0, 32'h80000)) - 32'h40000;
  endtask

  // Drives one request on a negedge; returns #1 after the accept edge.
  task automatic accept(input logic [63:0] tag, input logic [31:0] x, y, z,
                        input logic [31:0] px, py, pz);
    @(negedge clk);
    start  = 1'b1;
    tdp_in = {tag, x, y, z, px, py, pz};
    push_expect(tag, x, y, z, px, py, pz);
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
  endtask

  // Counts edges after the accept edge until valid is seen (bounded).
  task automatic wait_valid(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < LIMIT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 4;
    if (ready !== 1'b1)    begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    if (valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (zero_len !== 1'b0) begin n_fail++; $display("FAIL reset_zero_len: got %b want 0", zero_len); end
    if (dir_out !== '0)    begin n_fail++; $display("FAIL reset_dir_out: got %h want 0", dir_out); end
    rst_n = 1'b1;
  endtask

  task automatic run_one(input string name, input logic [63:0] tag, input logic [31:0] x, y, z,
                         input logic [31:0] px, py, pz);
    exp_t e;
    int   lat;
    bit   seen;
    accept(tag, x, y, z, px, py, pz);
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL %s_busy_ready: got %b want 0", name, ready); end
    wait_valid(lat, seen);
    e = sb.pop_front();
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: no valid within %0d edges, want %0d", name, lat, e.lat);
    end else begin
      n_checks += 5;
      if (lat !== e.lat)       begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, lat, e.lat); end
      if (dir_out !== e.dir)   begin n_fail++; $display("FAIL %s_dir_out: got %h want %h", name, dir_out, e.dir); end
      if (zero_len !== e.zl)   begin n_fail++; $display("FAIL %s_zero_len: got %b want %b", name, zero_len, e.zl); end
      if (ready !== 1'b1)      begin n_fail++; $display("FAIL %s_ready_at_valid: got %b want 1", name, ready); end
      @(negedge clk);
      if (valid !== 1'b0)      begin n_fail++; $display("FAIL %s_valid_width: got %b want 0", name, valid); end
    end
  endtask

  task automatic test_axis();
    run_one("axis", 64'hDEADBEEF, 32'h30000, 32'h0, 32'h0, sq(32'h30000), 32'h0, 32'h0);
    n_checks++;
    if (dir_out !== {64'hDEADBEEF, 32'h10000, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL axis_literal: got %h want x=0x10000 tag deadbeef", dir_out);
    end
  endtask

  task automatic test_signs();
    int dx, dy;
    run_one("signs", 64'h0123456789ABCDEF, -32'sh30000, 32'h40000, 32'h0,
            sq(-32'sh30000), sq(32'h40000), 32'h0);
    dx = $signed(dir_out[95:64]) + 39321;
    dy = $signed(dir_out[63:32]) - 52428;
    n_checks += 3;
    if (dx < -1 || dx > 1)      begin n_fail++; $display("FAIL signs_x: got %0d want -39321+-1", $signed(dir_out[95:64])); end
    if (dy < -1 || dy > 1)      begin n_fail++; $display("FAIL signs_y: got %0d want 52428+-1", $signed(dir_out[63:32])); end
    if (dir_out[31:0] !== 32'h0) begin n_fail++; $display("FAIL signs_z: got %h want 0", dir_out[31:0]); end
  endtask

  task automatic test_zero();
    run_one("zero", 64'hCAFEF00D00000001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    logic [63:0] tag;
    logic [31:0] x, y, z;
    for (int i = 0; i < 4; i++) begin
      rand_vec(tag, x, y, z);
      run_one("random", tag, x, y, z, sq(x), sq(y), sq(z));
    end
  endtask

  task automatic test_clamp();
    run_one("clamp_max", 64'h1, 32'h7FFF0000, 32'h0, 32'h0, sq(32'h7FFF0000), 32'h0, 32'h0);
    n_checks++;
    if (dir_out[95:64] !== 32'h10000) begin n_fail++; $display("FAIL clamp_max_x: got %h want 00010000", dir_out[95:64]); end
    run_one("clamp_negmax", 64'h2, 32'h80000000, 32'h0, 32'h0, sq(32'h80000000), 32'h0, 32'h0);
    n_checks++;
    if (dir_out[95:64] !== 32'hFFFF0000) begin n_fail++; $display("FAIL clamp_negmax_x: got %h want ffff0000", dir_out[95:64]); end
    run_one("clamp_lsb", 64'h3, 32'h1, 32'h0, 32'h0, sq(32'h1), 32'h0, 32'h0);
    n_checks++;
    if (zero_len !== 1'b1) begin n_fail++; $display("FAIL clamp_lsb_zero_len: got %b want 1", zero_len); end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    int   stray;
    accept(64'hAB, 32'h30000, 32'h40000, 32'h0, sq(32'h30000), sq(32'h40000), 32'h0);
    e = sb.pop_back();
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (valid !== 1'b0)    begin n_fail++; $display("FAIL midop_valid: got %b want 0", valid); end
    if (zero_len !== 1'b0) begin n_fail++; $display("FAIL midop_zero_len: got %b want 0", zero_len); end
    if (dir_out !== '0)    begin n_fail++; $display("FAIL midop_dir_out: got %h want 0", dir_out); end
    if (ready !== 1'b1)    begin n_fail++; $display("FAIL midop_ready: got %b want 1", ready); end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid) stray++;
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL midop_stray_valid: got %0d pulses want 0 (dropped %h)", stray, e.dir); end
    run_one("after_reset", 64'hBEEF, 32'h0, -32'sh50000, 32'h0, 32'h0, sq(-32'sh50000), 32'h0);
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [63:0] tag;
    logic [31:0] x, y, z;
    int          cyc, t_first, results, stray;
    @(negedge clk);
    rand_vec(tag, x, y, z);
    start  = 1'b1;
    tdp_in = {tag, x, y, z, sq(x), sq(y), sq(z)};
    push_expect(tag, x, y, z, sq(x), sq(y), sq(z));
    cyc = 0; t_first = 0; results = 0;
    while (results < 2 && cyc < 3 * LIMIT) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (valid) begin
        results++;
        e = sb.pop_front();
        n_checks += 3;
        if (dir_out !== e.dir) begin n_fail++; $display("FAIL b2b_dir_out%0d: got %h want %h", results, dir_out, e.dir); end
        if (zero_len !== e.zl) begin n_fail++; $display("FAIL b2b_zero_len%0d: got %b want %b", results, zero_len, e.zl); end
        if (ready !== 1'b1)    begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", results, ready); end
        if (results == 1) begin
          n_checks++;
          if (cyc != LAT + 1) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", cyc - 1, LAT); end
          t_first = cyc;
          rand_vec(tag, x, y, z);
          tdp_in = {tag, x, y, z, sq(x), sq(y), sq(z)};
          push_expect(tag, x, y, z, sq(x), sq(y), sq(z));
        end else begin
          n_checks++;
          if (cyc - t_first != LAT + 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - t_first, LAT + 1); end
          start = 1'b0;
        end
      end else begin
        rand_vec(tag, x, y, z);
        tdp_in = {tag, x, y, z, sq(x), sq(y), sq(z)};
      end
    end
    start = 1'b0;
    n_checks++;
    if (results != 2) begin n_fail++; $display("FAIL b2b_results: got %0d want 2", results); end
    stray = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (valid) stray++;
    end
    n_checks += 2;
    if (stray != 0)     begin n_fail++; $display("FAIL b2b_extra_valid: got %0d want 0", stray); end
    if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_scoreboard_left: got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_axis();
    test_signs();
    test_zero();
    test_random();
    test_clamp();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within 1000000 time units");
    $fatal(1);
  end
endmodule
`default_nettype wire
